// File: rtl/c_fetch_responder_if.sv
//------------------------------------------------------------------------------
// Module  : c_fetch_responder_if
// Brief   : Fetch handshake and backing-memory port bundle for c_fetch_responder
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface c_fetch_responder_if;
    logic        req_i;
    logic [31:0] addr_i;
    logic        kill_i;
    logic        flush_i;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] instr_o;
    logic [31:0] addr_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    modport slave (
        input  req_i, addr_i, kill_i, flush_i, mem_ack_i, mem_rdata_i,
        output ready_o, valid_o, instr_o, addr_o, mem_req_o, mem_addr_o
    );

    modport master (
        output req_i, addr_i, kill_i, flush_i, mem_ack_i, mem_rdata_i,
        input  ready_o, valid_o, instr_o, addr_o, mem_req_o, mem_addr_o
    );
endinterface

`default_nettype wire

// File: rtl/c_fetch_responder.sv
//------------------------------------------------------------------------------
// Module  : c_fetch_responder
// Brief   : Fetch responder with a direct-mapped word cache and miss port
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module c_fetch_responder #(
    parameter int NUM_LINES = 16
) (
    input  wire logic          clk,
    input  wire logic          reset,
    c_fetch_responder_if.slave bus
);
    localparam int c_idx_w = $clog2(NUM_LINES);
    localparam int c_tag_w = 32 - c_idx_w - 2;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_miss  = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;
    localparam logic [1:0] c_st_flush = 2'd3;

    logic [1:0]           r_state;
    logic [1:0]           w_next_state;
    logic                 r_flush_pending;
    logic [NUM_LINES-1:0] r_line_valid;
    logic [c_tag_w-1:0]   r_tag  [NUM_LINES];
    logic [31:0]          r_data [NUM_LINES];
    logic [c_idx_w-1:0]   r_flush_idx;
    logic                 r_valid_o;
    logic                 r_mem_req;
    logic [31:0]          r_instr;
    logic [31:0]          r_addr_o;
    logic [31:0]          r_req_addr;
    logic [31:0]          r_mem_addr;

    logic [c_idx_w-1:0]   w_idx;
    logic [c_tag_w-1:0]   w_tag;
    logic [c_idx_w-1:0]   w_fill_idx;
    logic                 w_hit;
    logic                 w_ready;
    logic                 w_accept_hit;
    logic                 w_accept_miss;
    logic                 w_mem_done;
    logic                 w_flush_now;
    logic                 w_fill;
    logic                 w_resp;
    logic                 w_set_pending;
    logic                 w_flush_clr;

    assign w_idx      = bus.addr_i[c_idx_w+1:2];
    assign w_tag      = bus.addr_i[31:c_idx_w+2];
    assign w_fill_idx = r_mem_addr[c_idx_w+1:2];
    assign w_hit      = r_line_valid[w_idx] && (r_tag[w_idx] == w_tag);

    always_ff @(posedge clk) begin
        if (reset) r_state <= c_st_idle;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (bus.flush_i)        w_next_state = c_st_flush;
                else if (w_accept_miss) w_next_state = c_st_miss;
            end
            c_st_miss: begin
                if (bus.mem_ack_i)                   w_next_state = w_flush_now ? c_st_flush : c_st_idle;
                else if (bus.flush_i || bus.kill_i)  w_next_state = c_st_drain;
            end
            c_st_drain: begin
                if (bus.mem_ack_i) w_next_state = w_flush_now ? c_st_flush : c_st_idle;
            end
            default: begin
                if (r_flush_idx == c_idx_w'(NUM_LINES - 1)) w_next_state = c_st_idle;
            end
        endcase
    end

    // A flush seen during an outstanding miss discards the returning word.
    always_comb begin
        w_ready       = (r_state == c_st_idle) && !bus.kill_i && !bus.flush_i;
        w_accept_hit  = w_ready && bus.req_i && w_hit;
        w_accept_miss = w_ready && bus.req_i && !w_hit;
        w_flush_now   = r_flush_pending || bus.flush_i;
        w_mem_done    = ((r_state == c_st_miss) || (r_state == c_st_drain)) && bus.mem_ack_i;
        w_fill        = w_mem_done && !w_flush_now;
        w_resp        = w_fill && (r_state == c_st_miss) && !bus.kill_i;
        w_set_pending = ((r_state == c_st_miss) || (r_state == c_st_drain)) && !bus.mem_ack_i && bus.flush_i;
        w_flush_clr   = (r_state == c_st_flush);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_line_valid    <= '0;
            r_flush_pending <= 1'b0;
            r_flush_idx     <= '0;
            r_valid_o       <= 1'b0;
            r_mem_req       <= 1'b0;
            r_instr         <= '0;
            r_addr_o        <= '0;
            r_req_addr      <= '0;
            r_mem_addr      <= '0;
        end else begin
            r_valid_o   <= 1'b0;
            r_flush_idx <= w_flush_clr ? r_flush_idx + 1'b1 : '0;
            if (w_accept_hit) begin
                r_valid_o <= 1'b1;
                r_instr   <= r_data[w_idx];
                r_addr_o  <= bus.addr_i;
            end
            if (w_accept_miss) begin
                r_mem_req  <= 1'b1;
                r_mem_addr <= {bus.addr_i[31:2], 2'b00};
                r_req_addr <= bus.addr_i;
            end
            if (w_mem_done) begin
                r_mem_req       <= 1'b0;
                r_flush_pending <= 1'b0;
            end
            if (w_set_pending) r_flush_pending <= 1'b1;
            if (w_fill)        r_line_valid[w_fill_idx] <= 1'b1;
            if (w_resp) begin
                r_valid_o <= 1'b1;
                r_instr   <= bus.mem_rdata_i;
                r_addr_o  <= r_req_addr;
            end
            if (w_flush_clr)   r_line_valid[r_flush_idx] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[w_fill_idx]  <= r_mem_addr[31:c_idx_w+2];
            r_data[w_fill_idx] <= bus.mem_rdata_i;
        end
    end

    assign bus.ready_o    = w_ready;
    assign bus.valid_o    = r_valid_o;
    assign bus.instr_o    = r_instr;
    assign bus.addr_o     = r_addr_o;
    assign bus.mem_req_o  = r_mem_req;
    assign bus.mem_addr_o = r_mem_addr;
endmodule

`default_nettype wire

// File: tb/tb_c_fetch_responder.sv
//------------------------------------------------------------------------------
// Module  : tb_c_fetch_responder
// Brief   : Directed self-checking bench for c_fetch_responder
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_c_fetch_responder;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    c_fetch_responder_if bus ();

    c_fetch_responder #(.NUM_LINES(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a);
        bus.req_i  = 1'b1;
        bus.addr_i = a;
        step();
        bus.req_i  = 1'b0;
    endtask

    task automatic mem_ack(input logic [31:0] d);
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = d;
        step();
        bus.mem_ack_i   = 1'b0;
    endtask

    task automatic test_reset();
        bus.req_i = 0; bus.addr_i = 0; bus.kill_i = 0; bus.flush_i = 0;
        bus.mem_ack_i = 0; bus.mem_rdata_i = 0;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        #1;
        checks++; if ({bus.valid_o, bus.mem_req_o, bus.ready_o} !== 3'b001) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 001", {bus.valid_o, bus.mem_req_o, bus.ready_o}); end
        checks++; if ({bus.instr_o, bus.addr_o, bus.mem_addr_o} !== 96'h0) begin
            errors++; $display("FAIL reset_data: got %h expected 0", {bus.instr_o, bus.addr_o, bus.mem_addr_o}); end
    endtask

    task automatic test_miss_fill();
        issue(32'h100);
        checks++; if ({bus.mem_req_o, bus.valid_o, bus.ready_o, bus.mem_addr_o} !== {3'b100, 32'h100}) begin
            errors++; $display("FAIL miss_req: got %b/%h expected 100/00000100", {bus.mem_req_o, bus.valid_o, bus.ready_o}, bus.mem_addr_o); end
        step(); step();
        mem_ack(32'h00450513);
        checks++; if ({bus.valid_o, bus.mem_req_o, bus.instr_o, bus.addr_o} !== {2'b10, 32'h00450513, 32'h100}) begin
            errors++; $display("FAIL miss_resp: got %b %h %h expected 10 00450513 00000100", {bus.valid_o, bus.mem_req_o}, bus.instr_o, bus.addr_o); end
        step();
        checks++; if ({bus.valid_o, bus.instr_o} !== {1'b0, 32'h00450513}) begin
            errors++; $display("FAIL miss_pulse_hold: got %b %h expected 0 00450513", bus.valid_o, bus.instr_o); end
    endtask

    task automatic test_hit();
        issue(32'h102);
        checks++; if ({bus.valid_o, bus.mem_req_o, bus.instr_o, bus.addr_o} !== {2'b10, 32'h00450513, 32'h102}) begin
            errors++; $display("FAIL hit_resp: got %b %h %h expected 10 00450513 00000102", {bus.valid_o, bus.mem_req_o}, bus.instr_o, bus.addr_o); end
    endtask

    task automatic test_conflict();
        issue(32'h140);
        checks++; if ({bus.mem_req_o, bus.mem_addr_o} !== {1'b1, 32'h140}) begin
            errors++; $display("FAIL conflict_req: got %b %h expected 1 00000140", bus.mem_req_o, bus.mem_addr_o); end
        step();
        mem_ack(32'h11111111);
        checks++; if ({bus.valid_o, bus.instr_o, bus.addr_o} !== {1'b1, 32'h11111111, 32'h140}) begin
            errors++; $display("FAIL conflict_resp: got %b %h %h expected 1 11111111 00000140", bus.valid_o, bus.instr_o, bus.addr_o); end
        issue(32'h100);
        checks++; if ({bus.mem_req_o, bus.valid_o, bus.mem_addr_o} !== {2'b10, 32'h100}) begin
            errors++; $display("FAIL conflict_evict: got %b %h expected 10 00000100", {bus.mem_req_o, bus.valid_o}, bus.mem_addr_o); end
        mem_ack(32'h00450513);
        checks++; if ({bus.valid_o, bus.instr_o} !== {1'b1, 32'h00450513}) begin
            errors++; $display("FAIL conflict_refill: got %b %h expected 1 00450513", bus.valid_o, bus.instr_o); end
    endtask

    task automatic test_kill();
        issue(32'h200);
        bus.kill_i = 1'b1;
        step();
        bus.kill_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if ({bus.ready_o, bus.valid_o, bus.mem_req_o} !== 3'b001) begin
                errors++; $display("FAIL kill_wait%0d: got %b expected 001", i, {bus.ready_o, bus.valid_o, bus.mem_req_o}); end
            if (i < 3) step();
        end
        mem_ack(32'h22222222);
        checks++; if ({bus.valid_o, bus.ready_o, bus.mem_req_o} !== 3'b010) begin
            errors++; $display("FAIL kill_drain: got %b expected 010", {bus.valid_o, bus.ready_o, bus.mem_req_o}); end
        issue(32'h200);
        checks++; if ({bus.valid_o, bus.mem_req_o, bus.instr_o} !== {2'b10, 32'h22222222}) begin
            errors++; $display("FAIL kill_refetch: got %b %h expected 10 22222222", {bus.valid_o, bus.mem_req_o}, bus.instr_o); end
        bus.kill_i = 1'b1; bus.req_i = 1'b1; bus.addr_i = 32'h500;
        #1;
        checks++; if (bus.ready_o !== 1'b0) begin
            errors++; $display("FAIL kill_ready: got %b expected 0", bus.ready_o); end
        step();
        bus.kill_i = 1'b0; bus.req_i = 1'b0;
        checks++; if ({bus.mem_req_o, bus.valid_o} !== 2'b00) begin
            errors++; $display("FAIL kill_req_drop: got %b expected 00", {bus.mem_req_o, bus.valid_o}); end
    endtask

    task automatic test_flush_idle();
        int cnt;
        issue(32'h100);
        mem_ack(32'h00450513);
        issue(32'h100);
        checks++; if ({bus.valid_o, bus.mem_req_o} !== 2'b10) begin
            errors++; $display("FAIL flush_prefill: got %b expected 10", {bus.valid_o, bus.mem_req_o}); end
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        cnt = 0;
        while (bus.ready_o === 1'b0 && cnt < 40) begin cnt++; step(); end
        checks++; if (cnt !== 16) begin
            errors++; $display("FAIL flush_cycles: got %0d expected 16", cnt); end
        issue(32'h100);
        checks++; if ({bus.mem_req_o, bus.valid_o} !== 2'b10) begin
            errors++; $display("FAIL flush_then_miss: got %b expected 10", {bus.mem_req_o, bus.valid_o}); end
        mem_ack(32'h00450513);
    endtask

    task automatic test_flush_miss();
        int  cnt;
        logic seen_valid;
        issue(32'h300);
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        checks++; if ({bus.ready_o, bus.valid_o, bus.mem_req_o} !== 3'b001) begin
            errors++; $display("FAIL fmiss_pending: got %b expected 001", {bus.ready_o, bus.valid_o, bus.mem_req_o}); end
        step();
        mem_ack(32'h33333333);
        checks++; if ({bus.valid_o, bus.mem_req_o, bus.ready_o} !== 3'b000) begin
            errors++; $display("FAIL fmiss_ack: got %b expected 000", {bus.valid_o, bus.mem_req_o, bus.ready_o}); end
        cnt = 0; seen_valid = 1'b0;
        while (bus.ready_o === 1'b0 && cnt < 40) begin
            cnt++; seen_valid = seen_valid | bus.valid_o; step();
        end
        checks++; if ({seen_valid, 8'(cnt)} !== {1'b0, 8'd16}) begin
            errors++; $display("FAIL fmiss_flush: got valid=%b cycles=%0d expected valid=0 cycles=16", seen_valid, cnt); end
        issue(32'h300);
        checks++; if ({bus.mem_req_o, bus.mem_addr_o} !== {1'b1, 32'h300}) begin
            errors++; $display("FAIL fmiss_nofill: got %b %h expected 1 00000300", bus.mem_req_o, bus.mem_addr_o); end
        mem_ack(32'h33333333);
        checks++; if ({bus.valid_o, bus.instr_o, bus.addr_o} !== {1'b1, 32'h33333333, 32'h300}) begin
            errors++; $display("FAIL fmiss_refetch: got %b %h %h expected 1 33333333 00000300", bus.valid_o, bus.instr_o, bus.addr_o); end
    endtask

    task automatic test_reset_mid_miss();
        issue(32'h100);
        mem_ack(32'h00450513);
        checks++; if ({bus.valid_o, bus.instr_o} !== {1'b1, 32'h00450513}) begin
            errors++; $display("FAIL rst_prefill: got %b %h expected 1 00450513", bus.valid_o, bus.instr_o); end
        issue(32'h404);
        checks++; if ({bus.mem_req_o, bus.mem_addr_o} !== {1'b1, 32'h404}) begin
            errors++; $display("FAIL rst_miss: got %b %h expected 1 00000404", bus.mem_req_o, bus.mem_addr_o); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if ({bus.mem_req_o, bus.valid_o} !== 2'b00) begin
            errors++; $display("FAIL rst_abort: got %b expected 00", {bus.mem_req_o, bus.valid_o}); end
        step();
        mem_ack(32'h44444444);
        checks++; if ({bus.valid_o, bus.ready_o, bus.mem_req_o} !== 3'b010) begin
            errors++; $display("FAIL rst_late_ack: got %b expected 010", {bus.valid_o, bus.ready_o, bus.mem_req_o}); end
        issue(32'h100);
        checks++; if ({bus.mem_req_o, bus.valid_o, bus.mem_addr_o} !== {2'b10, 32'h100}) begin
            errors++; $display("FAIL rst_invalidated: got %b %h expected 10 00000100", {bus.mem_req_o, bus.valid_o}, bus.mem_addr_o); end
        mem_ack(32'h00450513);
        checks++; if ({bus.valid_o, bus.instr_o, bus.addr_o} !== {1'b1, 32'h00450513, 32'h100}) begin
            errors++; $display("FAIL rst_refetch: got %b %h %h expected 1 00450513 00000100", bus.valid_o, bus.instr_o, bus.addr_o); end
    endtask

    initial begin
        test_reset();
        test_miss_fill();
        test_hit();
        test_conflict();
        test_kill();
        test_flush_idle();
        test_flush_miss();
        test_reset_mid_miss();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
